bnn_cfg_sequencer: RTL and testbench

Controller in front of the BNN XNOR-popcount neuron array.
- Owns the per-neuron weight and threshold registers and drives them flat to the datapath.
- Reloads them through a valid/ready configuration stream.
- Sequences inference requests through the combinational datapath with a registered, back-pressurable 1-deep output stage.
- Guarantees weights never change while an inference is in flight or its result is unconsumed.

---
 rtl/bnn_pkg.sv | 19 +
 rtl/bnn_cfg_regfile.sv | 47 ++++
 rtl/bnn_cfg_sequencer.sv | 154 +++++++++++++++
 tb/tb_bnn_cfg_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared sizing, reset defaults and FSM state type for the BNN configuration sequencer.
package bnn_pkg;

  localparam int NUM_NEURONS = 4;
  localparam int NUM_WEIGHTS = 6;
  localparam int THR_W       = 3;

  // Neuron 0 sits in the least significant slice.
  localparam logic [NUM_NEURONS*NUM_WEIGHTS-1:0] DEF_WEIGHTS =
    {6'b110011, 6'b001100, 6'b000111, 6'b111000};
  localparam logic [NUM_NEURONS*THR_W-1:0] DEF_THRESHOLDS = {4{3'd2}};

  typedef enum logic {S_RUN, S_LOAD} state_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bnn_cfg_regfile.sv
// Per-neuron weight/threshold storage with indexed write and flat read-out.
// Asynchronous reset returns every neuron to the package defaults.
module bnn_cfg_regfile
  import bnn_pkg::*;
#(
  parameter int NUM_NEURONS = bnn_pkg::NUM_NEURONS,
  parameter int NUM_WEIGHTS = bnn_pkg::NUM_WEIGHTS,
  parameter int THR_W       = bnn_pkg::THR_W,
  parameter int IDX_W       = idx_w(NUM_NEURONS),
  parameter logic [NUM_NEURONS*NUM_WEIGHTS-1:0] DEF_W = bnn_pkg::DEF_WEIGHTS,
  parameter logic [NUM_NEURONS*THR_W-1:0]       DEF_T = bnn_pkg::DEF_THRESHOLDS
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               i_we,
  input  logic [IDX_W-1:0]                   i_idx,
  input  logic [NUM_WEIGHTS-1:0]             i_weight,
  input  logic [THR_W-1:0]                   i_thr,
  output logic [NUM_NEURONS*NUM_WEIGHTS-1:0] o_weights,
  output logic [NUM_NEURONS*THR_W-1:0]       o_thresholds
);

  logic [NUM_WEIGHTS-1:0] r_w [NUM_NEURONS];
  logic [THR_W-1:0]       r_t [NUM_NEURONS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_w[i] <= DEF_W[i*NUM_WEIGHTS +: NUM_WEIGHTS];
        r_t[i] <= DEF_T[i*THR_W +: THR_W];
      end
    end else if (i_we) begin
      r_w[i_idx] <= i_weight;
      r_t[i_idx] <= i_thr;
    end
  end

  always_comb begin
    o_weights    = '0;
    o_thresholds = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      o_weights[i*NUM_WEIGHTS +: NUM_WEIGHTS] = r_w[i];
      o_thresholds[i*THR_W +: THR_W]          = r_t[i];
    end
  end

endmodule

// File: rtl/bnn_cfg_sequencer.sv
// Config/inference sequencer for the BNN XNOR-popcount neuron array.
// Optional inference counter enabled by defining BNN_PERF_CNT_EN.
module bnn_cfg_sequencer
  import bnn_pkg::*;
#(
  parameter int NUM_NEURONS = bnn_pkg::NUM_NEURONS,
  parameter int NUM_WEIGHTS = bnn_pkg::NUM_WEIGHTS,
  parameter int THR_W       = bnn_pkg::THR_W
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cfg_start,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [NUM_WEIGHTS+THR_W-1:0]       cfg_data,
  output logic                               cfg_busy,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_WEIGHTS-1:0]             in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_NEURONS-1:0]             out_data,
  output logic [NUM_WEIGHTS-1:0]             dp_in_data,
  output logic [NUM_NEURONS*NUM_WEIGHTS-1:0] dp_weights,
  output logic [NUM_NEURONS*THR_W-1:0]       dp_thresholds,
  input  logic [NUM_NEURONS-1:0]             dp_result,
  output logic [15:0]                        perf_count
);

  localparam int IDX_W = idx_w(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_t                 r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_cfg_idx, w_idx_nxt;
  logic                   r_cfg_pend, w_pend_nxt;
  logic                   r_out_valid;
  logic [NUM_NEURONS-1:0] r_out_data;
  logic                   w_we;
  logic                   w_drained;
  logic                   w_in_fire;
  logic                   w_out_fire;

  assign w_out_fire = r_out_valid & out_ready;
  // The output slot is free this cycle if empty or being consumed now.
  assign w_drained  = ~r_out_valid | out_ready;
  assign w_in_fire  = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_RUN;
      r_cfg_idx  <= '0;
      r_cfg_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cfg_idx  <= w_idx_nxt;
      r_cfg_pend <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_cfg_idx;
    w_pend_nxt  = r_cfg_pend;
    in_ready    = 1'b0;
    cfg_ready   = 1'b0;
    w_we        = 1'b0;
    case (r_state)
      S_RUN: begin
        in_ready = ~r_cfg_pend & ~cfg_start & w_drained;
        // A reload waits until the pending result leaves the output stage.
        if (cfg_start || r_cfg_pend) begin
          if (w_drained) begin
            w_state_nxt = S_LOAD;
            w_idx_nxt   = '0;
            w_pend_nxt  = 1'b0;
          end else begin
            w_pend_nxt  = 1'b1;
          end
        end
      end
      S_LOAD: begin
        cfg_ready = ~cfg_start;
        if (cfg_start) begin
          w_idx_nxt = '0;
        end else if (cfg_valid) begin
          w_we = 1'b1;
          if (r_cfg_idx == LAST_IDX) begin
            w_state_nxt = S_RUN;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_cfg_idx + IDX_W'(1);
          end
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Output stage: one registered, back-pressurable result slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_in_fire) begin
      r_out_valid <= 1'b1;
      r_out_data  <= dp_result;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  bnn_cfg_regfile #(
    .NUM_NEURONS (NUM_NEURONS),
    .NUM_WEIGHTS (NUM_WEIGHTS),
    .THR_W       (THR_W),
    .IDX_W       (IDX_W)
  ) u_regfile (
    .clk          (clk),
    .reset        (reset),
    .i_we         (w_we),
    .i_idx        (r_cfg_idx),
    .i_weight     (cfg_data[NUM_WEIGHTS-1:0]),
    .i_thr        (cfg_data[NUM_WEIGHTS +: THR_W]),
    .o_weights    (dp_weights),
    .o_thresholds (dp_thresholds)
  );

  assign cfg_busy   = (r_state == S_LOAD);
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign dp_in_data = in_data;

`ifdef BNN_PERF_CNT_EN
  logic [15:0] r_perf;
  logic        w_enter_load;

  assign w_enter_load = (r_state == S_RUN) && (w_state_nxt == S_LOAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf <= '0;
    end else if (w_enter_load) begin
      r_perf <= '0;
    end else if (w_in_fire && (r_perf != 16'hFFFF)) begin
      r_perf <= r_perf + 16'd1;
    end
  end

  assign perf_count = r_perf;
`else
  assign perf_count = '0;
`endif

endmodule

// File: tb/tb_bnn_cfg_sequencer.sv
// Directed bench for bnn_cfg_sequencer with a reference XNOR-popcount array on dp_*.
module tb_bnn_cfg_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_start, cfg_valid, cfg_ready, cfg_busy;
  logic [8:0]  cfg_data;
  logic        in_valid, in_ready;
  logic [5:0]  in_data;
  logic        out_valid, out_ready;
  logic [3:0]  out_data;
  logic [5:0]  dp_in_data;
  logic [23:0] dp_weights;
  logic [11:0] dp_thresholds;
  logic [3:0]  dp_result;
  logic [15:0] perf_count;

  int total = 0;
  int bad   = 0;

  localparam logic [23:0] DEF_W = {6'b110011, 6'b001100, 6'b000111, 6'b111000};
  localparam logic [11:0] DEF_T = {3'd2, 3'd2, 3'd2, 3'd2};

  typedef struct {
    logic [5:0] din;
    logic [3:0] exp;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  bnn_cfg_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_start     (cfg_start),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_data      (cfg_data),
    .cfg_busy      (cfg_busy),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .dp_in_data    (dp_in_data),
    .dp_weights    (dp_weights),
    .dp_thresholds (dp_thresholds),
    .dp_result     (dp_result),
    .perf_count    (perf_count)
  );

  // Reference neuron array: fires when matching bits >= threshold.
  always_comb begin
    int m;
    m = 0;
    dp_result = '0;
    for (int n = 0; n < 4; n++) begin
      m = 0;
      for (int b = 0; b < 6; b++)
        if (dp_in_data[b] == dp_weights[n*6+b]) m++;
      dp_result[n] = (m >= int'(dp_thresholds[n*3 +: 3]));
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic infer(input logic [5:0] d, input logic [3:0] exp, input string nm);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b1;
    #1 chk({nm, "_in_ready"}, in_ready, 1);
    tick;
    in_valid = 1'b0;
    #1;
    chk({nm, "_out_valid"}, out_valid, 1);
    chk({nm, "_out_data"}, out_data, exp);
  endtask

  task automatic cfg_pulse;
    cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
  endtask

  task automatic beat(input logic [8:0] d, input string nm);
    cfg_valid = 1'b1;
    cfg_data  = d;
    #1 chk({nm, "_cfg_ready"}, cfg_ready, 1);
    tick;
    cfg_valid = 1'b0;
  endtask

  task automatic load_defaults;
    cfg_pulse;
    beat({3'd2, 6'b111000}, "def0");
    beat({3'd2, 6'b000111}, "def1");
    beat({3'd2, 6'b001100}, "def2");
    beat({3'd2, 6'b110011}, "def3");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{6'b111000, 4'b1101};
    tbl[1] = '{6'b000111, 4'b1110};
    tbl[2] = '{6'b000000, 4'b1111};
    tbl[3] = '{6'b111111, 4'b1111};
    tbl[4] = '{6'b001100, 4'b0111};
    tbl[5] = '{6'b110011, 4'b1011};

    reset = 1'b1; cfg_start = 0; cfg_valid = 0; cfg_data = '0;
    in_valid = 0; in_data = '0; out_ready = 0;
    tick; tick;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_perf", perf_count, 0);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_weights", dp_weights, DEF_W);
    chk("rst_thresholds", dp_thresholds, DEF_T);
    reset = 1'b0;
    #1;
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_in_ready", in_ready, 1);

    // Default weights across the vector table
    for (int i = 0; i < 6; i++) infer(tbl[i].din, tbl[i].exp, $sformatf("tbl%0d", i));

    // Reload with {6, 000000}, checking busy window
    cfg_start = 1'b1;
    #1 chk("busy_at_start", cfg_busy, 0);
    tick;
    cfg_start = 1'b0;
    #1 chk("busy_after_start", cfg_busy, 1);
    chk("ov_cleared_on_load", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("busy_beat%0d", i), cfg_busy, 1);
      beat({3'd6, 6'b000000}, $sformatf("b6_%0d", i));
    end
    #1 chk("busy_after_last", cfg_busy, 0);
    infer(6'b000000, 4'b1111, "thr6_zero");
    infer(6'b000001, 4'b0000, "thr6_one");

    // Threshold corners: 0 always fires, 7 never fires
    cfg_pulse;
    beat({3'd0, 6'b000000}, "tc0");
    beat({3'd7, 6'b000000}, "tc1");
    beat({3'd6, 6'b000000}, "tc2");
    beat({3'd1, 6'b111111}, "tc3");
    infer(6'b000000, 4'b0101, "tcorner_zero");
    infer(6'b111111, 4'b1001, "tcorner_ones");

    // Back-pressure: pending result delays the reload
    tick;
    out_ready = 1'b0;
    infer(6'b111111, 4'b1001, "bp_first");
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 6'b000000;
    cfg_start = 1'b1;
    #1 chk("bp_in_ready_start", in_ready, 0);
    tick;
    cfg_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_in_ready%0d", k), in_ready, 0);
      chk($sformatf("bp_busy%0d", k), cfg_busy, 0);
      chk($sformatf("bp_out_valid%0d", k), out_valid, 1);
      chk($sformatf("bp_out_data%0d", k), out_data, 4'b1001);
      tick;
    end
    out_ready = 1'b1;
    #1 chk("bp_busy_release", cfg_busy, 0);
    tick;
    in_valid = 1'b0;
    #1;
    chk("bp_busy_loaded", cfg_busy, 1);
    chk("bp_out_drained", out_valid, 0);
    beat({3'd2, 6'b111000}, "bpd0");
    beat({3'd2, 6'b000111}, "bpd1");
    beat({3'd2, 6'b001100}, "bpd2");
    beat({3'd2, 6'b110011}, "bpd3");
    chk("bp_weights_restored", dp_weights, DEF_W);

    // Eight back-to-back inferences
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data = tbl[k % 6].din;
      #1 chk($sformatf("b2b_in_ready%0d", k), in_ready, 1);
      tick;
      chk($sformatf("b2b_valid%0d", k), out_valid, 1);
      chk($sformatf("b2b_data%0d", k), out_data, tbl[k % 6].exp);
    end
    in_valid = 1'b0;
    tick;
    chk("b2b_drained", out_valid, 0);
`ifdef BNN_PERF_CNT_EN
    chk("perf_8", perf_count, 8);
`else
    chk("perf_off", perf_count, 0);
`endif

    // Reset in the middle of a reload
    cfg_pulse;
    beat({3'd6, 6'b000000}, "mr0");
    beat({3'd6, 6'b000000}, "mr1");
    reset = 1'b1;
    #1;
    chk("mr_busy", cfg_busy, 0);
    chk("mr_weights", dp_weights, DEF_W);
    chk("mr_thresholds", dp_thresholds, DEF_T);
    tick;
    reset = 1'b0;
    #1 chk("mr_cfg_ready", cfg_ready, 0);
    infer(6'b111000, 4'b1101, "mr_infer");

    // cfg_start during load after one beat restarts at neuron 0
    cfg_pulse;
    beat({3'd7, 6'b110110}, "rs_a");
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = {3'd4, 6'b011011};
    #1 chk("rs_cfg_ready_blocked", cfg_ready, 0);
    tick;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    beat({3'd1, 6'b101010}, "rs_b0");
    beat({3'd3, 6'b010101}, "rs_b1");
    beat({3'd0, 6'b111111}, "rs_b2");
    #1 chk("rs_busy_before_last", cfg_busy, 1);
    beat({3'd5, 6'b000011}, "rs_b3");
    #1;
    chk("rs_busy_done", cfg_busy, 0);
    chk("rs_weights", dp_weights, {6'b000011, 6'b111111, 6'b010101, 6'b101010});
    chk("rs_thresholds", dp_thresholds, {3'd5, 3'd0, 3'd3, 3'd1});
    infer(6'b101010, 4'b0101, "rs_infer");
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
